// File: rtl/merge4.sv
// Four-to-one valid/ready stream merger with round-robin arbitration.
// Each output word carries the 2-bit index of the channel it came from.
module merge4 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [4*WIDTH-1:0] in_data,
   input  logic [3:0]         in_valid,
   output logic [3:0]         in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_sel,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [1:0] ptr;
   logic [1:0] win;
   logic [1:0] idx;
   logic       found;
   logic       load;
   logic       grant;

   assign load = !out_valid || out_ready;

   // First requesting channel scanning from ptr; ready is forced low while in reset.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      grant    = found && load && rst_n;
      in_ready = '0;
      if (grant)
         in_ready[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (grant) begin
         out_data  <= in_data[win*WIDTH +: WIDTH];
         out_sel   <= win;
         out_valid <= 1'b1;
         ptr       <= win + 2'd1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_merge4.sv
// Directed self-checking bench for merge4: reset, single source, round robin,
// idle-channel skipping, backpressure and mid-stream reset.
module tb_merge4;

   localparam int unsigned WIDTH = 16;

   logic               clk;
   logic               rst_n;
   logic [4*WIDTH-1:0] in_data;
   logic [3:0]         in_valid;
   logic [3:0]         in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_sel;
   logic               out_valid;
   logic               out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   merge4 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words(input logic [15:0] base);
      for (int i = 0; i < 4; i++)
         in_data[i*WIDTH +: WIDTH] = base + 16'(i);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      in_data   = '0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      set_words(16'hA000);
      #2;
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
      n_checks++;
      if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d expected 0", out_sel); end
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 16'hA000)
         begin n_fail++; $display("FAIL reset_first_word: got v=%b sel=%0d data=%h expected v=1 sel=0 data=a000", out_valid, out_sel, out_data); end
   endtask

   task automatic test_single_source();
      do_reset();
      out_ready = 1'b1;
      in_valid  = 4'b0100;
      in_data[2*WIDTH +: WIDTH] = 16'h1111;
      #1;
      n_checks++;
      if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready0: got %b expected 0100", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got out_valid=%b expected 0", out_valid); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 16'h1111)
         begin n_fail++; $display("FAIL single_word0: got v=%b sel=%0d data=%h expected v=1 sel=2 data=1111", out_valid, out_sel, out_data); end
      in_data[2*WIDTH +: WIDTH] = 16'h2222;
      #1;
      n_checks++;
      if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready1: got %b expected 0100", in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 16'h2222)
         begin n_fail++; $display("FAIL single_word1: got v=%b sel=%0d data=%h expected v=1 sel=2 data=2222", out_valid, out_sel, out_data); end
      in_valid = 4'b0000;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h2222 || out_sel !== 2'd2)
         begin n_fail++; $display("FAIL single_drain: got v=%b sel=%0d data=%h expected v=0 sel=2 data=2222", out_valid, out_sel, out_data); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ready;
      do_reset();
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      set_words(16'hA000);
      #1;
      for (int k = 0; k < 6; k++) begin
         exp_ready = 4'b0001 << (k % 4);
         n_checks++;
         if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, exp_ready); end
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== 16'hA000 + 16'(k % 4))
            begin n_fail++; $display("FAIL rr_word[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h", k, out_valid, out_sel, out_data, k % 4, 16'hA000 + 16'(k % 4)); end
      end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_skip_idle();
      do_reset();
      out_ready = 1'b1;
      set_words(16'hB000);
      in_valid = 4'b0010;
      tick();
      n_checks++;
      if (out_sel !== 2'd1 || out_data !== 16'hB001)
         begin n_fail++; $display("FAIL skip_first: got sel=%0d data=%h expected sel=1 data=b001", out_sel, out_data); end
      in_valid = 4'b1001;
      #1;
      n_checks++;
      if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_ready_a: got %b expected 1000", in_ready); end
      tick();
      n_checks++;
      if (out_sel !== 2'd3 || out_data !== 16'hB003)
         begin n_fail++; $display("FAIL skip_grant3: got sel=%0d data=%h expected sel=3 data=b003", out_sel, out_data); end
      n_checks++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_ready_b: got %b expected 0001", in_ready); end
      tick();
      n_checks++;
      if (out_sel !== 2'd0 || out_data !== 16'hB000)
         begin n_fail++; $display("FAIL skip_grant0: got sel=%0d data=%h expected sel=0 data=b000", out_sel, out_data); end
      tick();
      n_checks++;
      if (out_sel !== 2'd3 || out_valid !== 1'b1)
         begin n_fail++; $display("FAIL skip_grant3_again: got sel=%0d v=%b expected sel=3 v=1", out_sel, out_valid); end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      in_valid  = 4'b0001;
      in_data[0 +: WIDTH] = 16'hBEEF;
      tick();
      set_words(16'hC000);
      in_valid = 4'b1111;
      #1;
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 16'hBEEF || out_sel !== 2'd0)
            begin n_fail++; $display("FAIL bp_stall[%0d]: got rdy=%b v=%b data=%h sel=%0d expected rdy=0000 v=1 data=beef sel=0", c, in_ready, out_valid, out_data, out_sel); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 16'hC001)
         begin n_fail++; $display("FAIL bp_no_bubble: got v=%b sel=%0d data=%h expected v=1 sel=1 data=c001", out_valid, out_sel, out_data); end
      in_valid = 4'b0000;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got v=%b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      in_valid  = 4'b0100;
      in_data[2*WIDTH +: WIDTH] = 16'hD002;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2)
         begin n_fail++; $display("FAIL mid_setup: got v=%b sel=%0d expected v=1 sel=2", out_valid, out_sel); end
      set_words(16'hE000);
      in_valid = 4'b1111;
      rst_n    = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sel !== 2'd0 || in_ready !== 4'b0000)
         begin n_fail++; $display("FAIL mid_reset: got v=%b data=%h sel=%0d rdy=%b expected v=0 data=0000 sel=0 rdy=0000", out_valid, out_data, out_sel, in_ready); end
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001 || out_valid !== 1'b0)
         begin n_fail++; $display("FAIL mid_restart_ready: got rdy=%b v=%b expected rdy=0001 v=0", in_ready, out_valid); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 16'hE000)
         begin n_fail++; $display("FAIL mid_restart_word: got v=%b sel=%0d data=%h expected v=1 sel=0 data=e000", out_valid, out_sel, out_data); end
      in_valid = 4'b0000;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      in_data   = '0;
      test_reset();
      test_single_source();
      test_round_robin();
      test_skip_idle();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
